sdram_arbiter: RTL

- Shares the single SDRAM controller port among NUM_PORTS requesters, e.g. CPU ROM, WRAM and DMA/BSRAM.
- Each requester uses a level request with a one-cycle ack handshake. The arbiter grants round-robin.
- It drives the controller's edge-triggered rd/wr strobes, tracks the controller's busy, and returns read data per port.
- Sits between the core memory-mapping logic and the SDRAM controller.

---
 rtl/sdram_arb_pkg.sv | 31 +++
 rtl/sdram_arb_rr.sv | 48 ++++
 rtl/sdram_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
// Shared types and constants for the SDRAM port arbiter.
//   state_t    : arbiter FSM states
//   port_idx_t : requester index (wide enough for up to 4 ports)
//   AW_DEFAULT, DW, REFRESH_IDLE_DEFAULT : default widths / idle threshold
//   next_port(): round-robin successor of a port index
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

    localparam int AW_DEFAULT           = 25;
    localparam int DW                   = 16;
    localparam int REFRESH_IDLE_DEFAULT = 192;
    localparam int PORT_IDX_W           = 2;

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    // Successor of p in a ring of n ports.
    function automatic port_idx_t next_port(input port_idx_t p, input int n);
        if (int'(p) >= n - 1) return '0;
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/sdram_arb_rr.sv
// -----------------------------------------------------------------------------
// sdram_arb_rr
// Combinational round-robin picker: first pending port at or above ptr,
// wrapping to port 0.
//   pend     in  NUM_PORTS  pending request vector
//   ptr      in  port index where the search starts
//   winner   out port index of the selected requester (0 when none pending)
//   any_pend out at least one port is pending
// -----------------------------------------------------------------------------
module sdram_arb_rr
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 3
) (
    input  logic [NUM_PORTS-1:0] pend,
    input  port_idx_t            ptr,
    output port_idx_t            winner,
    output logic                 any_pend
);

    logic [2*NUM_PORTS-1:0] pend2;
    logic [2*NUM_PORTS-1:0] rot;
    logic                   found;
    int                     idx;

    // Doubling the vector turns the wrap-around search into a plain
    // shift followed by a lowest-set-bit search.
    assign pend2 = {pend, pend};
    assign rot   = pend2 >> ptr;

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        idx      = 0;
        any_pend = |pend;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                idx   = int'(ptr) + k;
                if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
                winner = port_idx_t'(idx);
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
// Shares one SDRAM controller port among NUM_PORTS requesters with a
// round-robin grant, level requests and a one-cycle ack per access.
//   req_rd/req_wr/req_word/req_addr/req_din : per-port request (held to ack)
//   req_dout / req_ack                      : per-port read data and ack pulse
//   mem_addr/mem_rd/mem_wr/mem_word/mem_din : controller command (edge strobes)
//   mem_dout / mem_busy                     : controller read data and busy
//   grant                                   : current / last granted port
// Optional: define SDRAM_ARB_REFRESH_EN to issue a keep-alive read of the
// last address after REFRESH_IDLE idle cycles.
// -----------------------------------------------------------------------------
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS    = 3,
    parameter int AW           = AW_DEFAULT,
    parameter int REFRESH_IDLE = REFRESH_IDLE_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          req_rd,
    input  logic [NUM_PORTS-1:0]          req_wr,
    input  logic [NUM_PORTS-1:0]          req_word,
    input  logic [NUM_PORTS-1:0][AW-1:0]  req_addr,
    input  logic [NUM_PORTS-1:0][DW-1:0]  req_din,
    output logic [NUM_PORTS-1:0][DW-1:0]  req_dout,
    output logic [NUM_PORTS-1:0]          req_ack,
    output logic [AW-1:0]                 mem_addr,
    output logic                          mem_rd,
    output logic                          mem_wr,
    output logic                          mem_word,
    output logic [DW-1:0]                 mem_din,
    input  logic [DW-1:0]                 mem_dout,
    input  logic                          mem_busy,
    output logic [$clog2(NUM_PORTS)-1:0]  grant
);

    localparam int GW = $clog2(NUM_PORTS);

    state_t                         state_q, state_d;
    logic [AW-1:0]                  mem_addr_q, mem_addr_d;
    logic [DW-1:0]                  mem_din_q, mem_din_d;
    logic                           mem_word_q, mem_word_d;
    logic                           mem_rd_q, mem_rd_d;
    logic                           mem_wr_q, mem_wr_d;
    logic                           we_q, we_d;
    port_idx_t                      grant_q, grant_d;
    port_idx_t                      ptr_q, ptr_d;
    logic [NUM_PORTS-1:0]           ack_q, ack_d;
    logic [NUM_PORTS-1:0][DW-1:0]   dout_q, dout_d;

    logic [NUM_PORTS-1:0]           pend;
    port_idx_t                      winner;
    logic                           any_pend;
    logic                           own_access;

`ifdef SDRAM_ARB_REFRESH_EN
    localparam int                  CNT_W = $clog2(REFRESH_IDLE + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(REFRESH_IDLE - 1);
    logic [CNT_W-1:0]               idle_cnt_q, idle_cnt_d;
    logic                           is_refresh_q, is_refresh_d;
    assign own_access = !is_refresh_q;
`else
    assign own_access = 1'b1;
`endif

    assign pend = req_rd | req_wr;

    sdram_arb_rr #(.NUM_PORTS(NUM_PORTS)) u_rr (
        .pend     (pend),
        .ptr      (ptr_q),
        .winner   (winner),
        .any_pend (any_pend)
    );

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_word_d = mem_word_q;
        mem_rd_d   = mem_rd_q;
        mem_wr_d   = mem_wr_q;
        we_d       = we_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        ack_d      = '0;
        dout_d     = dout_q;
`ifdef SDRAM_ARB_REFRESH_EN
        idle_cnt_d   = idle_cnt_q;
        is_refresh_d = is_refresh_q;
`endif

        unique case (state_q)
            IDLE: begin
                // mem_busy=0 also covers an access left running by a reset.
                if (any_pend && !mem_busy) begin
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (port_idx_t'(i) == winner) begin
                            mem_addr_d = req_addr[i];
                            mem_din_d  = req_din[i];
                            mem_word_d = req_word[i];
                            we_d       = req_wr[i];
                        end
                    end
                    grant_d = winner;
                    state_d = ISSUE;
`ifdef SDRAM_ARB_REFRESH_EN
                    is_refresh_d = 1'b0;
                    // A request colliding with the trigger keeps the count so
                    // the keep-alive follows right after this access.
                    if (idle_cnt_q != CNT_LAST) idle_cnt_d = '0;
`endif
                end
`ifdef SDRAM_ARB_REFRESH_EN
                else if (!any_pend) begin
                    if (idle_cnt_q == CNT_LAST) begin
                        if (!mem_busy) begin
                            // Re-read the last address; mem_addr/word/din keep
                            // their latched values.
                            we_d         = 1'b0;
                            is_refresh_d = 1'b1;
                            idle_cnt_d   = '0;
                            state_d      = ISSUE;
                        end
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
`endif
            end

            ISSUE: begin
                mem_rd_d = ~we_q;
                mem_wr_d = we_q;
                state_d  = WAIT_BUSY;
            end

            WAIT_BUSY: begin
                // Dropping the strobe as soon as busy is seen guarantees a
                // low cycle before the next rising edge.
                if (mem_busy) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    state_d  = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                if (!mem_busy) begin
                    if (own_access) begin
                        for (int i = 0; i < NUM_PORTS; i++) begin
                            if (port_idx_t'(i) == grant_q) begin
                                if (!we_q) dout_d[i] = mem_dout;
                                ack_d[i] = 1'b1;
                            end
                        end
                        ptr_d = next_port(grant_q, NUM_PORTS);
                    end
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers update with non-blocking assignments so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_word_q <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            we_q       <= 1'b0;
            grant_q    <= '0;
            ptr_q      <= '0;
            ack_q      <= '0;
            // NOTE: the read-data bank is a handful of registers, not a RAM,
            // so it is cleared on reset like any other state.
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_word_q <= mem_word_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            we_q       <= we_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            dout_q     <= dout_d;
        end
    end

`ifdef SDRAM_ARB_REFRESH_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt_q   <= '0;
            is_refresh_q <= 1'b0;
        end else begin
            idle_cnt_q   <= idle_cnt_d;
            is_refresh_q <= is_refresh_d;
        end
    end
`endif

    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_word = mem_word_q;
    assign mem_rd   = mem_rd_q;
    assign mem_wr   = mem_wr_q;
    assign req_ack  = ack_q;
    assign req_dout = dout_q;
    assign grant    = grant_q[GW-1:0];

endmodule
